workers_cpu_1_cpu_ocimem_engine: RTL and testbench

- Debug-memory access engine directly downstream of the Nios II debug slave sysclk stage.
- Consumes jdo and the take_action_ocimem_* / take_no_action_ocimem_a strobes.
- Performs single-word Avalon-MM master reads and writes into the debug RAM/bus.
- Returns MonDReg, monitor_ready and monitor_error to the debug slave tck stage for JTAG readback.

---
 rtl/workers_ocimem_pkg.sv | 17 +
 rtl/workers_cpu_1_cpu_ocimem_timeout.sv | 28 ++
 rtl/workers_cpu_1_cpu_ocimem_engine.sv | 163 ++++++++++++++++
 tb/tb_workers_cpu_1_cpu_ocimem_engine.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/workers_ocimem_pkg.sv
// rtl/workers_ocimem_pkg.sv - shared types and jdo field positions for the OCI memory engine
package workers_ocimem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam int unsigned JDO_RD_BIT   = 35;
  localparam int unsigned JDO_WDATA_HI = 34;
  localparam int unsigned JDO_WDATA_LO = 3;
  localparam int unsigned JDO_ADDR_LO  = 2;

  localparam logic [1:0] AVM_RESP_OKAY = 2'b00;

endpackage

// File: rtl/workers_cpu_1_cpu_ocimem_timeout.sv
// rtl/workers_cpu_1_cpu_ocimem_timeout.sv - stall counter that flags the last permitted stalled cycle
module workers_cpu_1_cpu_ocimem_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Expiry fires on the TIMEOUT-th stalled cycle so the request is high exactly TIMEOUT cycles.
  assign expired = enable && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/workers_cpu_1_cpu_ocimem_engine.sv
// rtl/workers_cpu_1_cpu_ocimem_engine.sv - JTAG debug memory engine issuing single-word Avalon-MM accesses
// Optional bus-stall abort is built when OCIMEM_TIMEOUT_EN is defined.
module workers_cpu_1_cpu_ocimem_engine
  import workers_ocimem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  input  logic [1:0]        avm_response,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  state_t state, state_next;

  logic              cmd_b, cmd_a, cmd_n, any_strobe;
  logic              bus_accept, bus_err, tmo_abort;
  logic [31:0]       mon_d_next;
  logic [ADDR_W-1:0] mon_a_next;
  logic              ready_next, error_next;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[37:36], jdo[1:0]};

  assign cmd_b      = take_action_ocimem_b;
  assign cmd_a      = take_action_ocimem_a && !take_action_ocimem_b;
  assign cmd_n      = take_no_action_ocimem_a && !take_action_ocimem_a && !take_action_ocimem_b;
  assign any_strobe = take_action_ocimem_a || take_action_ocimem_b || take_no_action_ocimem_a;

  assign bus_accept = (state != IDLE) && !avm_waitrequest;
  assign bus_err    = (avm_response != AVM_RESP_OKAY);

  assign avm_address    = BASE_ADDR + (32'(MonAReg) << 2);
  assign avm_writedata  = MonDReg;
  assign avm_byteenable = 4'hF;

`ifdef OCIMEM_TIMEOUT_EN
  logic tmo_clear, tmo_enable;

  assign tmo_clear  = (state == IDLE);
  assign tmo_enable = (state != IDLE) && avm_waitrequest;

  workers_cpu_1_cpu_ocimem_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_abort)
  );
`else
  localparam int unsigned unused_timeout = TIMEOUT;
  assign tmo_abort = 1'b0;
`endif

  // Request strobes are registered from the next state so they never glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      MonDReg       <= '0;
      MonAReg       <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
    end else begin
      state         <= state_next;
      MonDReg       <= mon_d_next;
      MonAReg       <= mon_a_next;
      monitor_ready <= ready_next;
      monitor_error <= error_next;
      avm_read      <= (state_next == READ);
      avm_write     <= (state_next == WRITE);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cmd_b) begin
          state_next = WRITE;
        end else if (cmd_a && jdo[JDO_RD_BIT]) begin
          state_next = READ;
        end else if (cmd_n) begin
          state_next = READ;
        end
      end
      READ, WRITE: begin
        if (bus_accept || tmo_abort) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mon_d_next = MonDReg;
    mon_a_next = MonAReg;
    ready_next = monitor_ready;
    error_next = monitor_error;
    case (state)
      IDLE: begin
        if (cmd_b) begin
          mon_d_next = jdo[JDO_WDATA_HI:JDO_WDATA_LO];
          ready_next = 1'b0;
          error_next = 1'b0;
        end else if (cmd_a) begin
          // An address-only load completes immediately, so ready never drops.
          mon_a_next = jdo[JDO_ADDR_LO +: ADDR_W];
          ready_next = !jdo[JDO_RD_BIT];
          error_next = 1'b0;
        end else if (cmd_n) begin
          mon_a_next = MonAReg + 1'b1;
          ready_next = 1'b0;
          error_next = 1'b0;
        end
      end
      READ: begin
        if (any_strobe) error_next = 1'b1;
        if (bus_accept) begin
          ready_next = 1'b1;
          if (bus_err) error_next = 1'b1;
          else         mon_d_next = avm_readdata;
        end else if (tmo_abort) begin
          ready_next = 1'b1;
          error_next = 1'b1;
        end
      end
      WRITE: begin
        if (any_strobe) error_next = 1'b1;
        if (bus_accept) begin
          ready_next = 1'b1;
          mon_a_next = MonAReg + 1'b1;
          if (bus_err) error_next = 1'b1;
        end else if (tmo_abort) begin
          ready_next = 1'b1;
          error_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_workers_cpu_1_cpu_ocimem_engine.sv
// tb/tb_workers_cpu_1_cpu_ocimem_engine.sv - scoreboard bench for the OCI memory engine
module tb_workers_cpu_1_cpu_ocimem_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic [31:0] avm_address, avm_writedata, avm_readdata;
  logic        avm_read, avm_write, avm_waitrequest;
  logic [3:0]  avm_byteenable;
  logic [1:0]  avm_response;
  logic [31:0] MonDReg;
  logic [7:0]  MonAReg;
  logic        monitor_ready, monitor_error;

  typedef struct {
    logic [31:0] mon_d;
    logic [7:0]  mon_a;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  workers_cpu_1_cpu_ocimem_engine #(
    .ADDR_W    (8),
    .BASE_ADDR (32'h0000_0000),
    .TIMEOUT   (4)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .avm_address             (avm_address),
    .avm_read                (avm_read),
    .avm_write               (avm_write),
    .avm_writedata           (avm_writedata),
    .avm_byteenable          (avm_byteenable),
    .avm_readdata            (avm_readdata),
    .avm_waitrequest         (avm_waitrequest),
    .avm_response            (avm_response),
    .MonDReg                 (MonDReg),
    .MonAReg                 (MonAReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] jdo_a(input logic rd, input logic [7:0] addr);
    logic [37:0] j;
    j = '0;
    j[35] = rd;
    j[9:2] = addr;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] data);
    logic [37:0] j;
    j = '0;
    j[34:3] = data;
    return j;
  endfunction

  // kind: 0 = take_action_ocimem_a, 1 = take_action_ocimem_b, 2 = take_no_action_ocimem_a
  task automatic strobe(input int kind, input logic [37:0] j);
    jdo = j;
    take_action_ocimem_a    = (kind == 0);
    take_action_ocimem_b    = (kind == 1);
    take_no_action_ocimem_a = (kind == 2);
    step();
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [7:0] a, input logic e);
    exp_t x;
    x.mon_d = d;
    x.mon_a = a;
    x.err   = e;
    exp_q.push_back(x);
  endtask

  task automatic wait_done(input string name);
    exp_t e;
    bit   seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (monitor_ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL %s_ready_timeout: monitor_ready=%0b required 1", name, monitor_ready);
    end
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL %s_scoreboard_empty: queue size 0 required >0", name);
      return;
    end
    e = exp_q.pop_front();
    tests_run++;
    if (MonDReg !== e.mon_d) begin
      tests_failed++;
      $display("FAIL %s_MonDReg: got %h required %h", name, MonDReg, e.mon_d);
    end
    tests_run++;
    if (MonAReg !== e.mon_a) begin
      tests_failed++;
      $display("FAIL %s_MonAReg: got %h required %h", name, MonAReg, e.mon_a);
    end
    tests_run++;
    if (monitor_error !== e.err) begin
      tests_failed++;
      $display("FAIL %s_monitor_error: got %0b required %0b", name, monitor_error, e.err);
    end
  endtask

  task automatic check_reset_values(input string name);
    tests_run++;
    if (MonDReg !== 32'h0 || MonAReg !== 8'h0) begin
      tests_failed++;
      $display("FAIL %s_regs: MonDReg=%h MonAReg=%h required 0/0", name, MonDReg, MonAReg);
    end
    tests_run++;
    if (avm_read !== 1'b0 || avm_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_req: read=%0b write=%0b required 0/0", name, avm_read, avm_write);
    end
    tests_run++;
    if (monitor_ready !== 1'b1 || monitor_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_status: ready=%0b error=%0b required 1/0", name, monitor_ready, monitor_error);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check_reset_values("reset");
    tests_run++;
    if (avm_byteenable !== 4'hF || avm_address !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_bus: be=%h addr=%h required f/00000000", avm_byteenable, avm_address);
    end
  endtask

  task automatic test_read();
    avm_readdata = 32'hDEADBEEF;
    push_exp(32'hDEADBEEF, 8'h10, 1'b0);
    strobe(0, jdo_a(1'b1, 8'h10));
    tests_run++;
    if (avm_read !== 1'b1 || avm_address !== 32'h40 || monitor_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_request: read=%0b addr=%h ready=%0b required 1/00000040/0",
               avm_read, avm_address, monitor_ready);
    end
    step();
    tests_run++;
    if (monitor_ready !== 1'b1 || avm_read !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_latency: ready=%0b read=%0b required 1/0", monitor_ready, avm_read);
    end
    wait_done("read");
  endtask

  task automatic test_write();
    int wc = 0;
    avm_waitrequest = 1'b1;
    push_exp(32'h12345678, 8'h11, 1'b0);
    strobe(1, jdo_b(32'h12345678));
    for (int i = 0; i < 12; i++) begin
      if (avm_write !== 1'b1) break;
      wc++;
      tests_run++;
      if (avm_writedata !== 32'h12345678 || avm_read !== 1'b0) begin
        tests_failed++;
        $display("FAIL write_data: wdata=%h read=%0b required 12345678/0", avm_writedata, avm_read);
      end
      avm_waitrequest = (wc < 4);
      step();
    end
    avm_waitrequest = 1'b0;
    tests_run++;
    if (wc != 4) begin
      tests_failed++;
      $display("FAIL write_hold: avm_write cycles=%0d required 4", wc);
    end
    wait_done("write");
  endtask

  task automatic test_wrap();
    push_exp(32'h12345678, 8'hFF, 1'b0);
    strobe(0, jdo_a(1'b0, 8'hFF));
    tests_run++;
    if (monitor_ready !== 1'b1 || avm_read !== 1'b0) begin
      tests_failed++;
      $display("FAIL addr_load: ready=%0b read=%0b required 1/0", monitor_ready, avm_read);
    end
    wait_done("addr_load");
    avm_readdata = 32'hA5A50001;
    push_exp(32'hA5A50001, 8'h00, 1'b0);
    strobe(2, '0);
    tests_run++;
    if (avm_read !== 1'b1 || avm_address !== 32'h0 || MonAReg !== 8'h00) begin
      tests_failed++;
      $display("FAIL wrap_request: read=%0b addr=%h MonAReg=%h required 1/00000000/00",
               avm_read, avm_address, MonAReg);
    end
    wait_done("wrap");
  endtask

  task automatic test_strobe_during_read();
    avm_waitrequest = 1'b1;
    avm_readdata    = 32'hCAFE0001;
    strobe(0, jdo_a(1'b1, 8'h20));
    step();
    strobe(1, jdo_b(32'hBADBAD00));
    tests_run++;
    if (monitor_error !== 1'b1 || avm_read !== 1'b1 || avm_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_drop: error=%0b read=%0b write=%0b required 1/1/0",
               monitor_error, avm_read, avm_write);
    end
    avm_waitrequest = 1'b0;
    push_exp(32'hCAFE0001, 8'h20, 1'b1);
    step();
    wait_done("busy_read");
    push_exp(32'hCAFE0001, 8'h21, 1'b0);
    strobe(0, jdo_a(1'b0, 8'h21));
    wait_done("error_clear");
  endtask

  task automatic test_read_error();
    avm_readdata = 32'h11111111;
    avm_response = 2'b10;
    push_exp(32'hCAFE0001, 8'h30, 1'b1);
    strobe(0, jdo_a(1'b1, 8'h30));
    step();
    avm_response = 2'b00;
    wait_done("read_error");
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [7:0]  a;
    for (int i = 0; i < 4; i++) begin
      d = $urandom();
      a = 8'h31 + 8'(i);
      avm_readdata = d;
      push_exp(d, a, 1'b0);
      strobe(2, '0);
      tests_run++;
      if (avm_address !== {22'h0, a, 2'b00}) begin
        tests_failed++;
        $display("FAIL b2b_addr%0d: got %h required %h", i, avm_address, {22'h0, a, 2'b00});
      end
      step();
      wait_done("b2b");
    end
  endtask

`ifdef OCIMEM_TIMEOUT_EN
  task automatic test_timeout();
    int rc = 0;
    avm_waitrequest = 1'b1;
    avm_readdata    = 32'h77777777;
    push_exp(MonDReg, 8'h40, 1'b1);
    strobe(0, jdo_a(1'b1, 8'h40));
    for (int i = 0; i < 20; i++) begin
      if (avm_read !== 1'b1) break;
      rc++;
      step();
    end
    tests_run++;
    if (rc != 4) begin
      tests_failed++;
      $display("FAIL timeout_hold: avm_read cycles=%0d required 4", rc);
    end
    wait_done("timeout");
    avm_waitrequest = 1'b0;
  endtask
`endif

  task automatic test_reset_during_write();
    avm_waitrequest = 1'b1;
    strobe(1, jdo_b(32'h55AA55AA));
    step();
    tests_run++;
    if (avm_write !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_write: avm_write=%0b required 1", avm_write);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    avm_waitrequest = 1'b0;
    check_reset_values("mid_reset");
  endtask

  initial begin
    reset = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    avm_readdata = '0;
    avm_waitrequest = 1'b0;
    avm_response = 2'b00;
    test_reset();
    test_read();
    test_write();
    test_wrap();
    test_strobe_during_read();
    test_read_error();
    test_back_to_back();
`ifdef OCIMEM_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_during_write();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time exceeded required completion");
    $fatal(1, "bench timeout");
  end

endmodule
